// File: rtl/prio_select_pipe_if.sv
// Valid/ready bus for the two-stage priority / round-robin word select.
// The design side uses the slave modport; the producer/consumer side uses master.
interface prio_select_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_CH  = 4
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                   i_valid;
  logic                   o_ready;
  logic [N_CH*WIDTH-1:0]  i_data;
  logic [N_CH-1:0]        i_cond;
  logic [WIDTH-1:0]       i_guard;
  logic [WIDTH-1:0]       i_default;
  logic                   i_mode;
  logic                   o_valid;
  logic                   i_ready;
  logic [WIDTH-1:0]       o_data;
  logic [SEL_W-1:0]       o_sel;
  logic                   o_hit;

  modport slave (
    input  i_valid, i_data, i_cond, i_guard, i_default, i_mode, i_ready,
    output o_ready, o_valid, o_data, o_sel, o_hit
  );

  modport master (
    output i_valid, i_data, i_cond, i_guard, i_default, i_mode, i_ready,
    input  o_ready, o_valid, o_data, o_sel, o_hit
  );
endinterface

// File: rtl/prio_select_pipe.sv
// Two-stage conditional word select: stage 1 registers the per-channel qualify
// compare, stage 2 arbitrates (fixed priority or round-robin) into the output registers.
module prio_select_pipe #(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       N_CH       = 4,
  parameter logic [WIDTH-1:0]  THRESH     = WIDTH'(8),
  parameter logic [N_CH-1:0]   GUARD_MASK = '0
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  prio_select_pipe_if.slave  bus
);
  localparam int unsigned      SEL_W   = $clog2(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic                  s1_valid;
  logic [N_CH*WIDTH-1:0] s1_data;
  logic [WIDTH-1:0]      s1_default;
  logic                  s1_mode;
  logic [N_CH-1:0]       s1_qual;
  logic [SEL_W-1:0]      ptr;

  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_hit;

  logic                  guard_ok;
  logic [N_CH-1:0]       qual_in;
  logic                  s2_adv;
  logic                  s1_adv;
  logic                  accept;

  logic                  fix_hit;
  logic [SEL_W-1:0]      fix_sel;
  logic                  rr_hit;
  logic [SEL_W-1:0]      rr_sel;
  logic [SEL_W-1:0]      rr_cand;
  logic                  win_hit;
  logic [SEL_W-1:0]      win_sel;
  logic [WIDTH-1:0]      win_data;
  logic [SEL_W-1:0]      ptr_next;

  // Handshake: o_ready looks through to i_ready so a full pipe can still stream.
  assign s2_adv = !out_valid || bus.i_ready;
  assign s1_adv = s1_valid && s2_adv;
  assign accept = bus.i_valid && bus.o_ready;

  assign bus.o_ready = !s1_valid || s2_adv;
  assign bus.o_valid = out_valid;
  assign bus.o_data  = out_data;
  assign bus.o_sel   = out_sel;
  assign bus.o_hit   = out_hit;

  // Unmasked channels ignore the guard; an equal guard fails the compare.
  assign guard_ok = bus.i_guard < THRESH;
  assign qual_in  = bus.i_cond & (~GUARD_MASK | {N_CH{guard_ok}});

  always_comb begin
    fix_hit = 1'b0;
    fix_sel = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (s1_qual[SEL_W'(c)]) begin
        fix_hit = 1'b1;
        fix_sel = SEL_W'(c);
      end
    end
  end

  // Search ptr, ptr+1, ... with wrap; descending loop leaves the nearest hit.
  always_comb begin
    int sum;
    rr_hit  = 1'b0;
    rr_sel  = '0;
    rr_cand = '0;
    sum     = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      sum = int'(ptr) + k;
      if (sum >= int'(N_CH)) begin
        sum = sum - int'(N_CH);
      end
      rr_cand = SEL_W'(sum);
      if (s1_qual[rr_cand]) begin
        rr_hit = 1'b1;
        rr_sel = rr_cand;
      end
    end
  end

  assign win_hit  = s1_mode ? rr_hit : fix_hit;
  assign win_sel  = s1_mode ? rr_sel : fix_sel;
  assign win_data = s1_data[int'(win_sel)*WIDTH +: WIDTH];
  assign ptr_next = (win_sel == LAST_CH) ? '0 : win_sel + SEL_W'(1);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_default <= '0;
      s1_mode    <= 1'b0;
      s1_qual    <= '0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_data    <= bus.i_data;
        s1_default <= bus.i_default;
        s1_mode    <= bus.i_mode;
        s1_qual    <= qual_in;
      end else if (s1_adv) begin
        s1_valid   <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_hit   <= 1'b0;
      ptr       <= '0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
      end
      if (s1_adv) begin
        out_data <= win_hit ? win_data : s1_default;
        out_sel  <= win_hit ? win_sel : '0;
        out_hit  <= win_hit;
        // Only round-robin hits move the pointer; fixed and miss leave it.
        if (s1_mode && win_hit) begin
          ptr <= ptr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_select_pipe.sv
// Bench for prio_select_pipe: directed scenarios then random traffic, checked
// against a transaction-level model that arbitrates each accepted input in order.
module tb_prio_select_pipe;
  localparam int W = 8;
  localparam int N = 4;
  localparam logic [W-1:0] TH = 8'd8;
  localparam logic [N-1:0] GM = 4'b0001;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   sel;
    logic         hit;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  int m_ptr = 0;
  bit acc = 1'b0;
  exp_t exp_q[$];
  logic [W-1:0] got_d[$];
  logic [1:0]   got_s[$];

  prio_select_pipe_if #(.WIDTH(W), .N_CH(N)) bus();

  prio_select_pipe #(
    .WIDTH(W), .N_CH(N), .THRESH(TH), .GUARD_MASK(GM)
  ) dut (
    .i_clk(clk),
    .i_arst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [N*W-1:0] d, input logic [N-1:0] cond,
                                 input logic [W-1:0] g, input logic [W-1:0] dflt,
                                 input logic mode);
    exp_t e;
    bit q[N];
    int win = -1;
    for (int c = 0; c < N; c++) q[c] = cond[c] && (!GM[c] || (g < TH));
    if (mode) begin
      for (int k = 0; k < N; k++)
        if (win < 0 && q[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end else begin
      for (int c = 0; c < N; c++)
        if (win < 0 && q[c]) win = c;
    end
    if (win < 0) begin
      e.data = dflt; e.sel = 2'd0; e.hit = 1'b0;
    end else begin
      e.data = d[win*W +: W]; e.sel = win[1:0]; e.hit = 1'b1;
      if (mode) m_ptr = (win + 1) % N;
    end
    return e;
  endfunction

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc = bus.i_valid && bus.o_ready;
    if (exp_q.size() == 0) begin
      chk("idle_valid", 32'(bus.o_valid), 32'(0));
    end else if (bus.o_valid) begin
      e = exp_q[0];
      chk("out_data", 32'(bus.o_data), 32'(e.data));
      chk("out_sel", 32'(bus.o_sel), 32'(e.sel));
      chk("out_hit", 32'(bus.o_hit), 32'(e.hit));
      if (bus.i_ready) begin
        void'(exp_q.pop_front());
        got_d.push_back(bus.o_data);
        got_s.push_back(bus.o_sel);
      end
    end
    if (acc) exp_q.push_back(model(bus.i_data, bus.i_cond, bus.i_guard, bus.i_default, bus.i_mode));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N*W-1:0] d, input logic [N-1:0] cond,
                      input logic [W-1:0] g, input logic [W-1:0] dflt, input logic mode);
    int i = 0;
    bus.i_valid = 1'b1; bus.i_data = d; bus.i_cond = cond;
    bus.i_guard = g; bus.i_default = dflt; bus.i_mode = mode;
    do begin
      cycle();
      i++;
    end while (!acc && i < 50);
    if (!acc) chk("send_timeout", 32'(bus.o_ready), 32'(1));
  endtask

  task automatic drain();
    int i = 0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.o_valid) && i < 50) begin
      cycle();
      i++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    logic [N*W-1:0] d1;
    logic [1:0] rr_exp [5];
    d1 = {8'd44, 8'd33, 8'd22, 8'd11};
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_cond = '0; bus.i_guard = '0;
    bus.i_default = '0; bus.i_mode = 1'b0; bus.i_ready = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.o_valid), 32'(0));
    chk("rst_data", 32'(bus.o_data), 32'(0));
    chk("rst_sel", 32'(bus.o_sel), 32'(0));
    chk("rst_hit", 32'(bus.o_hit), 32'(0));
    chk("rst_ready", 32'(bus.o_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed priority with two-cycle latency
    got_d.delete(); got_s.delete();
    send(d1, 4'b0110, 8'd0, 8'd0, 1'b0);
    bus.i_valid = 1'b0;
    chk("lat_cycle1", 32'(bus.o_valid), 32'(0));
    cycle();
    chk("lat_cycle2", 32'(bus.o_valid), 32'(1));
    chk("fix_data", 32'(bus.o_data), 32'(22));
    chk("fix_sel", 32'(bus.o_sel), 32'(1));
    chk("fix_hit", 32'(bus.o_hit), 32'(1));
    drain();

    // Guard just below and at the threshold
    got_d.delete(); got_s.delete();
    send(d1, 4'b0011, 8'd7, 8'd0, 1'b0);
    drain();
    chk("guard7_data", 32'(got_d[0]), 32'(11));
    chk("guard7_sel", 32'(got_s[0]), 32'(0));
    got_d.delete(); got_s.delete();
    send(d1, 4'b0011, 8'd8, 8'd0, 1'b0);
    drain();
    chk("guard8_data", 32'(got_d[0]), 32'(22));
    chk("guard8_sel", 32'(got_s[0]), 32'(1));

    // Round-robin rotation over five back-to-back transactions
    got_d.delete(); got_s.delete();
    for (int i = 0; i < 5; i++) send(d1, 4'b1111, 8'd0, 8'd0, 1'b1);
    drain();
    chk("rr_count", 32'(got_s.size()), 32'(5));
    for (int i = 0; i < 5; i++) chk("rr_seq", 32'(got_s[i]), 32'(rr_exp[i]));
    chk("rr_ptr", 32'(dut.ptr), 32'(1));

    // No qualifier: default word, pointer untouched
    got_d.delete(); got_s.delete();
    send(d1, 4'b0000, 8'd0, 8'hA5, 1'b1);
    drain();
    chk("dflt_data", 32'(got_d[0]), 32'(8'hA5));
    chk("dflt_sel", 32'(got_s[0]), 32'(0));
    chk("dflt_ptr", 32'(dut.ptr), 32'(1));
    send(d1, 4'b1111, 8'd0, 8'd0, 1'b1);
    drain();
    chk("rr_after_dflt", 32'(got_s[1]), 32'(1));

    // Stall: two accepted, third blocked, output held
    got_d.delete(); got_s.delete();
    bus.i_ready = 1'b0;
    send(32'h00000010, 4'b0001, 8'd0, 8'd0, 1'b0);
    send(32'h00000020, 4'b0001, 8'd0, 8'd0, 1'b0);
    bus.i_data = 32'h00000030;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 32'(bus.o_ready), 32'(0));
      chk("stall_hold", 32'(bus.o_data), 32'(8'h10));
      cycle();
    end
    bus.i_ready = 1'b1;
    send(32'h00000030, 4'b0001, 8'd0, 8'd0, 1'b0);
    drain();
    chk("stall_count", 32'(got_d.size()), 32'(3));
    chk("stall_ord0", 32'(got_d[0]), 32'(8'h10));
    chk("stall_ord1", 32'(got_d[1]), 32'(8'h20));
    chk("stall_ord2", 32'(got_d[2]), 32'(8'h30));

    // Reset with both stages full
    bus.i_ready = 1'b0;
    send(d1, 4'b1111, 8'd0, 8'd0, 1'b1);
    send(d1, 4'b1111, 8'd0, 8'd0, 1'b1);
    bus.i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.o_valid), 32'(0));
    chk("midrst_ptr", 32'(dut.ptr), 32'(0));
    chk("midrst_hit", 32'(bus.o_hit), 32'(0));
    exp_q.delete();
    m_ptr = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.i_ready = 1'b1;
    send(d1, 4'b1111, 8'd0, 8'd0, 1'b1);
    bus.i_valid = 1'b0;
    chk("post_rst_lat1", 32'(bus.o_valid), 32'(0));
    cycle();
    chk("post_rst_lat2", 32'(bus.o_valid), 32'(1));
    chk("post_rst_sel", 32'(bus.o_sel), 32'(0));
    chk("post_rst_data", 32'(bus.o_data), 32'(11));
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.i_valid   = 1'($urandom_range(0, 1));
      bus.i_ready   = ($urandom_range(0, 3) != 0);
      bus.i_data    = $urandom;
      bus.i_cond    = 4'($urandom_range(0, 15));
      bus.i_guard   = 8'($urandom_range(0, 15));
      bus.i_default = 8'($urandom);
      bus.i_mode    = 1'($urandom_range(0, 1));
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prio_select_pipe.md
Name: prio_select_pipe

Overview:
- Parametrised successor to the single-cycle conditional output select.
- Chooses one of N_CH input words per transaction. Qualification is per channel, with an optional per-channel guard compare against a threshold. The winner is picked by fixed priority or round-robin; if nothing qualifies, a default word is output.
- The compare and the arbitration sit in separate registered stages, so the long compare-to-mux path is split. Valid/ready handshakes on both sides.
- Sits between datapath producers and a registered consumer.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- N_CH, 4: number of candidate channels (>=2).
- THRESH, 8: unsigned guard threshold, WIDTH bits.
- GUARD_MASK, 0: N_CH-bit mask. Bit c=1 means channel c also requires i_guard < THRESH to qualify.
- SEL_W (localparam), $clog2(N_CH): width of the channel index.

Ports:
- i_clk  in  1  clock, rising edge.
- i_arst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream transaction valid.
- o_ready  out  1  block can accept this cycle.
- i_data  in  N_CH*WIDTH  candidate words; channel c at bits [c*WIDTH +: WIDTH].
- i_cond  in  N_CH  per-channel request.
- i_guard  in  WIDTH  unsigned guard operand.
- i_default  in  WIDTH  word output when no channel qualifies.
- i_mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- o_valid  out  1  output transaction valid.
- i_ready  in  1  downstream accepts.
- o_data  out  WIDTH  selected word.
- o_sel  out  SEL_W  winning channel index; 0 when o_hit=0.
- o_hit  out  1  at least one channel qualified.

Behaviour:
- One clock. Reset is asynchronous and active-low. All state clears immediately on i_arst_n=0.
- Reset values: o_valid=0, o_data=0, o_sel=0, o_hit=0, stage-1 valid=0, round-robin pointer=0.
- Stage 1 (S1) captures when i_valid && o_ready. It registers:
  - i_data, i_default, i_mode;
  - qual[c] = i_cond[c] && (!GUARD_MASK[c] || i_guard < THRESH). The compare is unsigned, WIDTH bits.
- Stage 2 (S2, the output registers) loads from S1 when S1 is valid and S2 can advance.
- Advance rules:
  - s2_adv = !o_valid || i_ready.
  - s1_adv = s1_valid && s2_adv.
  - o_ready = !s1_valid || s2_adv. This is combinational from i_ready.
- Latency: 2 cycles from input acceptance to o_valid with no stall. Throughput: 1 transaction per cycle.
- Stall: while o_valid && !i_ready, o_data, o_sel and o_hit hold stable, and S1 holds its contents. o_ready=0 only when S1 is also full.
- o_valid falls only after a cycle with i_ready=1 and no new S1 transfer.
- Arbitration in S2, on the registered qual:
  - Fixed (mode=0): lowest index c with qual[c]=1 wins.
  - Round-robin (mode=1): the first qualified index searching ptr, ptr+1, ..., wrapping modulo N_CH.
  - No qualifier: o_data=default, o_hit=0, o_sel=0.
- Pointer update: only on an S1-to-S2 transfer with mode=1 and a hit. ptr <= winner+1, wrapping N_CH-1 to 0.
  - Fixed-mode transactions and no-hit transactions leave ptr unchanged.
  - The pointer persists across mode changes.
  - For non-power-of-2 N_CH, ptr never exceeds N_CH-1.
- Mode is per transaction, captured with the data. Mixing modes in back-to-back transactions is legal.
- Simultaneous events:
  - Accept into S1 and transfer S1 to S2 in the same cycle is legal. S1 takes the new data.
  - Output consumed and refilled in the same cycle keeps o_valid=1.
- Reset mid-operation: in-flight transactions are discarded without being output. Output resumes normally after reset deasserts; the first accepted input appears 2 cycles later.
- The guard compare affects only channels whose GUARD_MASK bit is set. A guard equal to THRESH fails.

Test Plan:
- Defaults, mode=0, i_cond=4'b0110, data {ch3..0}={44,33,22,11}, i_ready=1 -> 2 cycles later o_valid=1, o_data=22, o_sel=1, o_hit=1.
- GUARD_MASK=4'b0001, i_cond=4'b0011, data ch0=11, ch1=22. Guard=7 gives o_data=11, o_sel=0. Guard=8 gives o_data=22, o_sel=1.
- Mode=1, i_cond=4'b1111 for 5 back-to-back transactions -> o_sel sequence 0,1,2,3,0. Pointer ends at 1.
- i_cond=0, i_default=8'hA5 -> o_data=A5, o_hit=0, o_sel=0. A following mode=1 transaction still starts at the unchanged pointer.
- Stall: 3 inputs sent with i_ready=0 -> o_ready drops after 2 are accepted, and the output holds the first transaction. Raising i_ready drains all 3 in order with no loss or duplication.
- Assert i_arst_n=0 with both stages full -> o_valid=0, ptr=0 immediately. After release, a new input appears 2 cycles after acceptance.
